cordic_host_sequencer: RTL and testbench

- Initiator side of the CORDIC controller interface.
- Accepts one rotation or vectoring request at a time over a valid/ready port and registers the operands.
- Pulses start to the CORDIC FSM, then watches the FSM state bus for completion.
- Captures x/y/z results and presents them on a valid/ready response port, with an error flag for timeout or wrong-mode sequencing.

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_host_sequencer.sv | 138 +++++++++++++
 tb/tb_cordic_host_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// +----------------------------------------------------------------------------+
// | cordic_pkg: CORDIC FSM state codes, host sequencer states, mode constants   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cordic_pkg;

  typedef enum logic [2:0] {
    CS_IDLE      = 3'd0,
    CS_ROT_SETUP = 3'd1,
    CS_ROT_ITER  = 3'd2,
    CS_VEC_SETUP = 3'd3,
    CS_VEC_ITER  = 3'd4
  } cordic_state_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } host_state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // True when the FSM code belongs to the active family of the given mode.
  function automatic logic in_family(input logic mode, input logic [2:0] st);
    if (mode == MODE_VEC)
      return (st == 3'(CS_VEC_SETUP)) || (st == 3'(CS_VEC_ITER));
    else
      return (st == 3'(CS_ROT_SETUP)) || (st == 3'(CS_ROT_ITER));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_host_sequencer.sv
// +----------------------------------------------------------------------------+
// | cordic_host_sequencer: issues one CORDIC operation per request and returns  |
// | the captured result (or an error) on a valid/ready response port. Rev 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module cordic_host_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32,
  parameter int TCW     = 6
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic [WIDTH-1:0] req_z,
  output logic             start,
  output logic             cordic_mode,
  output logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] z_in,
  input  logic [2:0]       cordic_state,
  input  logic [WIDTH-1:0] x_out,
  input  logic [WIDTH-1:0] y_out,
  input  logic [WIDTH-1:0] z_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_x,
  output logic [WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_err
);

  host_state_t    r_state;
  logic [TCW-1:0] r_cnt;

  logic [TCW-1:0] w_cnt_inc;
  logic           w_timeout;
  logic           w_fsm_idle;
  logic           w_expected;

  // Saturating increment; the timeout fires on the cycle the count would reach TIMEOUT.
  assign w_cnt_inc  = (r_cnt == {TCW{1'b1}}) ? r_cnt : r_cnt + TCW'(1);
  assign w_timeout  = (w_cnt_inc == TCW'(TIMEOUT));
  assign w_fsm_idle = (cordic_state == 3'(CS_IDLE));
  assign w_expected = in_family(cordic_mode, cordic_state);

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      req_ready   <= 1'b0;
      start       <= 1'b0;
      cordic_mode <= 1'b0;
      x_in        <= '0;
      y_in        <= '0;
      z_in        <= '0;
      rsp_valid   <= 1'b0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_z       <= '0;
      rsp_err     <= 1'b0;
    end else begin
      start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            x_in        <= req_x;
            y_in        <= req_y;
            z_in        <= req_z;
            cordic_mode <= req_mode;
            req_ready   <= 1'b0;
            start       <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!w_fsm_idle) begin
            if (w_expected) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_DONE;
            end else begin
              {rsp_x, rsp_y, rsp_z} <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end
          end else if (w_timeout) begin
            {rsp_x, rsp_y, rsp_z} <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (w_fsm_idle) begin
            rsp_x     <= x_out;
            rsp_y     <= y_out;
            rsp_z     <= z_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (!w_expected || w_timeout) begin
            {rsp_x, rsp_y, rsp_z} <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_host_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_cordic_host_sequencer: scoreboard bench with a behavioural CORDIC FSM    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cordic_host_sequencer;

  localparam int WIDTH  = 16;
  localparam int B_NORM = 0;
  localparam int B_HOLD = 1;
  localparam int B_WRONG = 2;

  logic             clka = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_mode = 1'b0;
  logic [WIDTH-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic             start;
  logic             cordic_mode;
  logic [WIDTH-1:0] x_in, y_in, z_in;
  logic [2:0]       cordic_state;
  logic [WIDTH-1:0] x_out = '0, y_out = '0, z_out = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_x, rsp_y, rsp_z;
  logic             rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int start_cnt = 0;
  int start_rel = 0;
  int m_behave = B_NORM;
  int m_iter = 0;
  logic [3*WIDTH:0] sb[$];

  cordic_host_sequencer #(.WIDTH(WIDTH), .TIMEOUT(32), .TCW(6)) dut (
    .clka(clka), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .start(start), .cordic_mode(cordic_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .cordic_state(cordic_state),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  always @(negedge clka) begin
    if (start) begin
      start_cnt = start_cnt + 1;
      start_rel = cyc - accept_cyc;
    end
  end

  // Behavioural CORDIC FSM: setup for one cycle, iterate nine cycles, back to idle.
  always @(posedge clka or negedge reset) begin
    if (!reset) begin
      cordic_state <= 3'd0;
      m_iter       <= 0;
    end else begin
      case (cordic_state)
        3'd0: if (start && m_behave != B_HOLD)
                cordic_state <= ((m_behave == B_WRONG) ^ cordic_mode) ? 3'd3 : 3'd1;
        3'd1: begin cordic_state <= 3'd2; m_iter <= 0; end
        3'd3: begin cordic_state <= 3'd4; m_iter <= 0; end
        3'd2, 3'd4: begin
          if (m_iter == 8) cordic_state <= 3'd0;
          else m_iter <= m_iter + 1;
        end
        default: cordic_state <= 3'd0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic mode, input logic [WIDTH-1:0] x, y, z,
                          input logic e_err, input logic [WIDTH-1:0] ex, ey, ez);
    int n;
    @(negedge clka);
    req_mode = mode; req_x = x; req_y = y; req_z = z; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clka);
      n++;
    end
    if (!req_ready) chk("req_accept", 0, 1);
    @(posedge clka);
    #1;
    req_valid  = 1'b0;
    accept_cyc = cyc;
    start_cnt  = 0;
    sb.push_back({e_err, ex, ey, ez});
    chk("x_in", x_in, x);
    chk("y_in", y_in, y);
    chk("z_in", z_in, z);
    chk("cordic_mode", cordic_mode, mode);
  endtask

  task automatic finish_rsp(input int exp_lat, input int hold);
    int n;
    logic [3*WIDTH:0] e;
    n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!rsp_valid && n < 100);
    if (!rsp_valid) begin
      chk("rsp_wait", 0, 1);
      return;
    end
    chk("rsp_latency", cyc - accept_cyc, exp_lat);
    chk("start_count", start_cnt, 1);
    chk("start_cycle", start_rel, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("rsp_err", rsp_err, e[3*WIDTH]);
    chk("rsp_x", rsp_x, e[3*WIDTH-1:2*WIDTH]);
    chk("rsp_y", rsp_y, e[2*WIDTH-1:WIDTH]);
    chk("rsp_z", rsp_z, e[WIDTH-1:0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clka);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_x", rsp_x, e[3*WIDTH-1:2*WIDTH]);
      chk("hold_y", rsp_y, e[2*WIDTH-1:WIDTH]);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clka);
    #1;
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_req_ready", req_ready, 1);
  endtask

  task automatic wait_model_idle();
    int n;
    n = 0;
    while (cordic_state != 3'd0 && n < 50) begin
      @(negedge clka);
      n++;
    end
    chk("model_idle", cordic_state, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clka);
    chk("rst_start", start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_x_in", x_in, 0);
    reset = 1'b1;

    // Rotation
    m_behave = B_NORM;
    x_out = 16'h1BB6; y_out = 16'h1000; z_out = 16'h0005;
    send_req(1'b0, 16'h26DD, 16'h0000, 16'h2183, 1'b0, 16'h1BB6, 16'h1000, 16'h0005);
    finish_rsp(12, 0);

    // Vectoring with five cycles of backpressure
    x_out = 16'h16A0; y_out = 16'h0000; z_out = 16'h0C90;
    send_req(1'b1, 16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h16A0, 16'h0000, 16'h0C90);
    finish_rsp(12, 5);

    // Timeout in S_WAIT_BUSY
    m_behave = B_HOLD;
    send_req(1'b0, 16'h0123, 16'h0456, 16'h0789, 1'b1, 16'h0, 16'h0, 16'h0);
    finish_rsp(33, 0);

    // Mode mismatch: rotation request, FSM enters vectoring
    m_behave = B_WRONG;
    x_out = 16'hBEEF;
    send_req(1'b0, 16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b1, 16'h0, 16'h0, 16'h0);
    finish_rsp(2, 0);
    wait_model_idle();

    // Busy rejection: second request held during the first operation
    m_behave = B_NORM;
    x_out = 16'h7001; y_out = 16'h7002; z_out = 16'h7003;
    send_req(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 16'h7001, 16'h7002, 16'h7003);
    @(negedge clka);
    req_mode = 1'b1; req_x = 16'h4444; req_y = 16'h5555; req_z = 16'h6666; req_valid = 1'b1;
    repeat (4) @(negedge clka);
    chk("busy_req_ready", req_ready, 0);
    chk("busy_x_in", x_in, 16'h1111);
    finish_rsp(12, 0);
    chk("busy_x_in_after_hs", x_in, 16'h1111);
    @(posedge clka);
    #1;
    req_valid  = 1'b0;
    accept_cyc = cyc;
    start_cnt  = 0;
    sb.push_back({1'b0, 16'h7001, 16'h7002, 16'h7003});
    chk("second_x_in", x_in, 16'h4444);
    chk("second_mode", cordic_mode, 1);
    finish_rsp(12, 0);

    // Reset during S_WAIT_DONE, then a normal operation
    send_req(1'b0, 16'h0F0F, 16'h00F0, 16'h0F00, 1'b0, 16'h7001, 16'h7002, 16'h7003);
    repeat (5) @(negedge clka);
    reset = 1'b0;
    #1;
    chk("midrst_start", start, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_x_in", x_in, 0);
    chk("midrst_req_ready", req_ready, 0);
    sb.delete();
    @(negedge clka);
    reset = 1'b1;
    x_out = 16'h1234; y_out = 16'h5678; z_out = 16'h9ABC;
    send_req(1'b1, 16'h0101, 16'h0202, 16'h0303, 1'b0, 16'h1234, 16'h5678, 16'h9ABC);
    finish_rsp(12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
